// File: rtl/ram_arbiter.sv
// Two-port fixed-priority RAM arbiter with bounded starvation for port 1.
// Optional statistics counters are enabled by defining RAM_ARB_STATS_EN.
module ram_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MAXWAIT = 4
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [WIDTH-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] m1_rdata,
  output logic [WIDTH-1:0] ram_address,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_enw,
  input  logic [WIDTH-1:0] ram_rdata
`ifdef RAM_ARB_STATS_EN
  ,
  input  logic             stat_clear,
  output logic [31:0]      stat_gnt0,
  output logic [31:0]      stat_gnt1,
  output logic [31:0]      stat_conflict
`endif
);

  localparam logic [7:0] MAXW = 8'(MAXWAIT);

  typedef enum logic [1:0] {ST_IDLE, ST_P0, ST_P1, ST_P1_FORCED} arb_state_e;

  arb_state_e       state;
  logic [7:0]       wait1_q, wait1_d;
  logic             m0_rvalid_q, m0_rvalid_d;
  logic             m1_rvalid_q, m1_rvalid_d;
  logic [WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [WIDTH-1:0] m1_rdata_q, m1_rdata_d;

  // The state is purely per-cycle; no ownership is carried between cycles.
  always_comb begin
    state = ST_IDLE;
    if (m1_req && (wait1_q == MAXW)) state = ST_P1_FORCED;
    else if (m0_req)                 state = ST_P0;
    else if (m1_req)                 state = ST_P1;
  end

  always_comb begin
    m0_gnt      = (state == ST_P0);
    m1_gnt      = (state == ST_P1) || (state == ST_P1_FORCED);
    ram_address = m0_addr;
    ram_wdata   = m0_wdata;
    ram_enw     = 1'b0;
    if (m1_gnt) begin
      ram_address = m1_addr;
      ram_wdata   = m1_wdata;
      ram_enw     = m1_we;
    end else if (m0_gnt) begin
      ram_enw = m0_we;
    end
  end

  always_comb begin
    wait1_d = wait1_q;
    if (!m1_req || m1_gnt)   wait1_d = '0;
    else if (wait1_q != MAXW) wait1_d = wait1_q + 8'd1;

    m0_rvalid_d = m0_gnt && !m0_we;
    m1_rvalid_d = m1_gnt && !m1_we;
    m0_rdata_d  = m0_rvalid_d ? ram_rdata : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? ram_rdata : m1_rdata_q;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wait1_q     <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      wait1_q     <= wait1_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

`ifdef RAM_ARB_STATS_EN
  logic [31:0] stat_gnt0_q, stat_gnt0_d;
  logic [31:0] stat_gnt1_q, stat_gnt1_d;
  logic [31:0] stat_conflict_q, stat_conflict_d;

  // Saturating counters; clear wins over a same-cycle increment.
  always_comb begin
    stat_gnt0_d     = stat_gnt0_q;
    stat_gnt1_d     = stat_gnt1_q;
    stat_conflict_d = stat_conflict_q;
    if (stat_clear) begin
      stat_gnt0_d     = '0;
      stat_gnt1_d     = '0;
      stat_conflict_d = '0;
    end else begin
      if (m0_gnt && (stat_gnt0_q != '1))             stat_gnt0_d     = stat_gnt0_q + 32'd1;
      if (m1_gnt && (stat_gnt1_q != '1))             stat_gnt1_d     = stat_gnt1_q + 32'd1;
      if (m0_req && m1_req && (stat_conflict_q != '1)) stat_conflict_d = stat_conflict_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      stat_gnt0_q     <= '0;
      stat_gnt1_q     <= '0;
      stat_conflict_q <= '0;
    end else begin
      stat_gnt0_q     <= stat_gnt0_d;
      stat_gnt1_q     <= stat_gnt1_d;
      stat_conflict_q <= stat_conflict_d;
    end
  end

  assign stat_gnt0     = stat_gnt0_q;
  assign stat_gnt1     = stat_gnt1_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus queues expected grants and read
// data; a single monitor process compares whenever the DUT presents outputs.
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        ram_init_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] ram_address, ram_wdata, ram_rdata;
  logic        ram_enw;
`ifdef RAM_ARB_STATS_EN
  logic        stat_clear = 1'b0;
  logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

  ram_arbiter #(.WIDTH(32), .MAXWAIT(4)) dut (
    .clock(clock), .nreset(nreset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_enw(ram_enw),
    .ram_rdata(ram_rdata)
`ifdef RAM_ARB_STATS_EN
    ,
    .stat_clear(stat_clear), .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1),
    .stat_conflict(stat_conflict)
`endif
  );

  always #5 clock = ~clock;

  // RAM model: unwritten words read back as 0xA50000<addr>.
  logic [31:0]  mem [256];
  logic [255:0] wr_ok;
  always @(posedge clock or negedge ram_init_n) begin
    if (!ram_init_n) wr_ok <= '0;
    else if (ram_enw) begin
      mem[ram_address[7:0]]   <= ram_wdata;
      wr_ok[ram_address[7:0]] <= 1'b1;
    end
  end
  assign ram_rdata = wr_ok[ram_address[7:0]] ? mem[ram_address[7:0]]
                                             : {24'hA50000, ram_address[7:0]};

  typedef struct {
    logic        g0, g1, enw;
    logic [31:0] addr, wdata;
    logic        st;
    logic [31:0] s0, s1, sc;
  } exp_t;

  exp_t        gq[$];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        done = 1'b0;
  logic        st_chk = 1'b0;
  logic [31:0] st_s0 = '0, st_s1 = '0, st_sc = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drives one cycle of requests and queues the hand-computed outcome.
  task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic eg0, input logic eg1, input logic [31:0] er);
    exp_t e;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    e.g0 = eg0; e.g1 = eg1;
    e.enw = (eg0 && w0) || (eg1 && w1);
    e.addr = eg1 ? a1 : a0;
    e.wdata = eg1 ? d1 : d0;
    e.st = st_chk; e.s0 = st_s0; e.s1 = st_s1; e.sc = st_sc;
    gq.push_back(e);
    if (eg0 && !w0) q0.push_back(er);
    if (eg1 && !w1) q1.push_back(er);
    @(posedge clock); #1;
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
  endtask

  // Monitor: the only process that compares and counts.
  initial begin
    exp_t e;
    logic [31:0] x;
    int cycles = 0;
    forever begin
      @(negedge clock or negedge nreset);
      if (!nreset) begin
        #1;
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
      end else begin
        cycles++;
        if (gq.size() != 0) begin
          e = gq.pop_front();
          chk("m0_gnt", 32'(m0_gnt), 32'(e.g0));
          chk("m1_gnt", 32'(m1_gnt), 32'(e.g1));
          chk("ram_enw", 32'(ram_enw), 32'(e.enw));
          chk("ram_address", ram_address, e.addr);
          if (e.enw) chk("ram_wdata", ram_wdata, e.wdata);
`ifdef RAM_ARB_STATS_EN
          if (e.st) begin
            chk("stat_gnt0", stat_gnt0, e.s0);
            chk("stat_gnt1", stat_gnt1, e.s1);
            chk("stat_conflict", stat_conflict, e.sc);
          end
`endif
        end
        if (m0_rvalid) begin
          if (q0.size() == 0) chk("m0_rvalid_unexpected", 32'h1, 32'h0);
          else begin x = q0.pop_front(); chk("m0_rdata", m0_rdata, x); end
        end
        if (m1_rvalid) begin
          if (q1.size() == 0) chk("m1_rvalid_unexpected", 32'h1, 32'h0);
          else begin x = q1.pop_front(); chk("m1_rdata", m1_rdata, x); end
        end
        if (done || cycles > 3000) begin
          chk("timeout", 32'(cycles > 3000), 32'h0);
          chk("q0_drained", 32'(q0.size()), 32'h0);
          chk("q1_drained", 32'(q1.size()), 32'h0);
          chk("gq_drained", 32'(gq.size()), 32'h0);
          $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
          $finish;
        end
      end
    end
  end

  logic [9:0] dual_pat = 10'b10000_10000;

  initial begin
    #2 ram_init_n = 1'b1;
    repeat (2) @(posedge clock);
    #2 nreset = 1'b1;
    @(posedge clock); #1;

    // Port 0 only: write then read back.
    step(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    step(1, 0, 32'h10, 32'h0,        0, 0, 32'h0, 32'h0, 1, 0, 32'hDEADBEEF);
    idle();

    // Continuous contention: 0,0,0,0,1 repeating.
    for (int unsigned i = 0; i < 10; i++)
      step(1, 0, 32'h10, 32'h0, 1, 0, 32'h30, 32'h0, !dual_pat[i], dual_pat[i],
           dual_pat[i] ? 32'hA5000030 : 32'hDEADBEEF);
    idle();

    // Port 1 only: alternating write/read of 0x20.
    step(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h11111111, 0, 1, 32'h0);
    step(0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0,        0, 1, 32'h11111111);
    step(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h22222222, 0, 1, 32'h0);
    step(0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0,        0, 1, 32'h22222222);

    // Cross-port read-after-write.
    step(0, 0, 32'h0,  32'h0, 1, 1, 32'h40, 32'h33333333, 0, 1, 32'h0);
    step(1, 0, 32'h40, 32'h0, 0, 0, 32'h0,  32'h0,        1, 0, 32'h33333333);

    // Port 1 denied 3 times, drops, then 4 denials before the forced grant.
    for (int unsigned i = 0; i < 3; i++)
      step(1, 0, 32'h10, 32'h0, 1, 1, 32'h60, 32'h44444444, 1, 0, 32'hDEADBEEF);
    step(1, 0, 32'h10, 32'h0, 0, 1, 32'h60, 32'h44444444, 1, 0, 32'hDEADBEEF);
    for (int unsigned i = 0; i < 4; i++)
      step(1, 0, 32'h10, 32'h0, 1, 1, 32'h60, 32'h44444444, 1, 0, 32'hDEADBEEF);
    step(1, 0, 32'h10, 32'h0, 1, 1, 32'h60, 32'h44444444, 0, 1, 32'h0);
    step(1, 0, 32'h60, 32'h0, 0, 0, 32'h0,  32'h0,        1, 0, 32'h44444444);

    // Reset asserted while m0_rvalid is high.
    step(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h22222222);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clock); #1 nreset = 1'b0;
    @(posedge clock); #2 nreset = 1'b1;
    @(posedge clock); #1;
    step(1, 0, 32'h40, 32'h0, 0, 0, 32'h0,  32'h0, 1, 0, 32'h33333333);
    step(0, 0, 32'h0,  32'h0, 1, 0, 32'h60, 32'h0, 0, 1, 32'h44444444);
    idle();

`ifdef RAM_ARB_STATS_EN
    stat_clear = 1'b1;
    idle();
    stat_clear = 1'b0;
    for (int unsigned i = 0; i < 10; i++)
      step(1, 0, 32'h10, 32'h0, 1, 0, 32'h30, 32'h0, !dual_pat[i], dual_pat[i],
           dual_pat[i] ? 32'hA5000030 : 32'hDEADBEEF);
    st_chk = 1'b1; st_s0 = 32'd8; st_s1 = 32'd2; st_sc = 32'd10;
    stat_clear = 1'b1;
    idle();
    stat_clear = 1'b0;
    st_s0 = 32'd0; st_s1 = 32'd0; st_sc = 32'd0;
    idle();
    st_chk = 1'b0;
`endif

    idle();
    idle();
    done = 1'b1;
  end

endmodule
